// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parametrised UART receiver with configurable frame format (5..9 data bits,
// none/odd/even parity, 1 or 2 stop bits) and oversampling ratio. Each bit is
// decided by a 3-sample majority vote around mid-bit. Framing, parity and
// break conditions are reported alongside the received word.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rxEn         receiver enable; dropping it mid-frame aborts the frame
//   rxIn         asynchronous serial line, idles high
//   rxBusy       a frame is being received
//   rxDone       one-cycle pulse when a frame completes
//   rxErr        a stop bit voted 0 (valid with rxDone)
//   rxParityErr  parity mismatch (valid with rxDone)
//   rxBreak      framing error with all data and parity bits 0 (valid with rxDone)
//   rxOut        last received data word, held until the next rxDone
module uart_rx_param #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic                 rxBreak,
    output logic [DATA_BITS-1:0] rxOut
);

    localparam int DIV    = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] SAMPLE0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] SAMPLE1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] SAMPLE2   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        BITS_END  = 4'(DATA_BITS);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } RxState;

    RxState                 state;
    logic                   sync1;
    logic                   sync2;
    logic                   linePrev;
    logic [DIV_W-1:0]       divCnt;
    logic [TICK_W-1:0]      tickCnt;
    logic [3:0]             bitCnt;
    logic                   stopCnt;
    logic                   stopErr;
    logic                   samp0;
    logic                   samp1;
    logic                   parityBit;
    logic [DATA_BITS-1:0]   shiftReg;

    logic vote;
    logic frameErr;
    logic parityFail;

    // The third sample is taken live from the synchronised line on the
    // tick where the vote is used, so only two samples need storing.
    assign vote = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

    // Frame-level results used on the final stop-bit vote.
    assign frameErr   = stopErr | ~vote;
    assign parityFail = (PARITY == 1) ? ~(^{shiftReg, parityBit}) :
                        (PARITY == 2) ?  (^{shiftReg, parityBit}) : 1'b0;

    // Single receiver process: line synchroniser, baud/oversample tick
    // generation, majority sampling and the frame state machine. The tick
    // counters are cleared on start detection so sampling is phase-locked to
    // the falling edge of the start bit. Start detection looks for a 1->0
    // transition of the synchronised line, so after a break the line has to
    // return high before another frame can begin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            linePrev    <= 1'b1;
            divCnt      <= '0;
            tickCnt     <= '0;
            bitCnt      <= '0;
            stopCnt     <= 1'b0;
            stopErr     <= 1'b0;
            samp0       <= 1'b1;
            samp1       <= 1'b1;
            parityBit   <= 1'b0;
            shiftReg    <= '0;
            rxBusy      <= 1'b0;
            rxDone      <= 1'b0;
            rxErr       <= 1'b0;
            rxParityErr <= 1'b0;
            rxBreak     <= 1'b0;
            rxOut       <= '0;
        end else begin
            sync1       <= rxIn;
            sync2       <= sync1;
            linePrev    <= sync2;
            rxDone      <= 1'b0;
            rxErr       <= 1'b0;
            rxParityErr <= 1'b0;
            rxBreak     <= 1'b0;

            if (state != IDLE && !rxEn) begin
                state  <= IDLE;
                rxBusy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxEn && linePrev && !sync2) begin
                            state   <= START;
                            rxBusy  <= 1'b1;
                            divCnt  <= '0;
                            tickCnt <= '0;
                            bitCnt  <= '0;
                            stopCnt <= 1'b0;
                            stopErr <= 1'b0;
                        end
                    end
                    default: begin
                        if (divCnt == DIV_LAST) begin
                            divCnt  <= '0;
                            tickCnt <= (tickCnt == TICK_LAST) ? '0 : tickCnt + 1'b1;
                            if (tickCnt == SAMPLE0) samp0 <= sync2;
                            if (tickCnt == SAMPLE1) samp1 <= sync2;

                            // Mid-bit: the vote is complete on this tick.
                            if (tickCnt == SAMPLE2) begin
                                case (state)
                                    START: begin
                                        if (vote) begin
                                            state  <= IDLE;
                                            rxBusy <= 1'b0;
                                        end
                                    end
                                    DATA: begin
                                        shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
                                        bitCnt   <= bitCnt + 1'b1;
                                    end
                                    PARITY_BIT: begin
                                        parityBit <= vote;
                                    end
                                    STOP: begin
                                        if (stopCnt == STOP_LAST) begin
                                            rxOut       <= shiftReg;
                                            rxDone      <= 1'b1;
                                            rxErr       <= frameErr;
                                            rxParityErr <= parityFail;
                                            rxBreak     <= frameErr && (shiftReg == '0) &&
                                                           (PARITY == 0 || !parityBit);
                                            rxBusy      <= 1'b0;
                                            state       <= IDLE;
                                        end else begin
                                            stopErr <= stopErr | ~vote;
                                            stopCnt <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end

                            // End of bit: move to the next field.
                            if (tickCnt == TICK_LAST) begin
                                case (state)
                                    START: state <= DATA;
                                    DATA: begin
                                        if (bitCnt == BITS_END)
                                            state <= (PARITY != 0) ? PARITY_BIT : STOP;
                                    end
                                    PARITY_BIT: state <= STOP;
                                    default: ;
                                endcase
                            end
                        end else begin
                            divCnt <= divCnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
// Self-checking bench for uart_rx_param. Four receivers share clock, reset
// and enable; one serial stimulus line is routed to the receiver chosen by
// 'sel' while the others see an idle-high line:
//   0: defaults (8N1, 1248 clk/bit)
//   1: 8N1, 128 clk/bit
//   2: 8N2, 128 clk/bit
//   3: 7E1, 128 clk/bit
// Expected results come from a frame-level model of the serial format.
module tb_uart_rx_param;

    localparam int FAST_CLOCK = 1228800;

    logic clk = 1'b0;
    logic rst;
    logic rxEn;
    logic rxLine;
    int   sel;

    logic [3:0] rxInV;
    logic [3:0] busyV, doneV, errV, perrV, brkV;
    logic [7:0] outA, outB, outC;
    logic [6:0] outD;

    logic       selBusy;
    logic [8:0] selOut;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;
    int flagLeak    = 0;
    logic [8:0] lastOut;
    logic lastErr, lastPerr, lastBrk, lastBusy;

    int         prevDone;
    int         rSel, rBits, rStop, rPeriod;
    logic [8:0] rData;
    bit         rHasPar, rPbit;
    bit   [1:0] rStopV;

    always #5 clk = ~clk;

    // Route the stimulus line to the selected receiver only.
    always_comb begin
        rxInV      = '1;
        rxInV[sel] = rxLine;
    end

    always_comb begin
        selBusy = busyV[sel];
        case (sel)
            0:       selOut = {1'b0, outA};
            1:       selOut = {1'b0, outB};
            2:       selOut = {1'b0, outC};
            default: selOut = {2'b0, outD};
        endcase
    end

    uart_rx_param dutA (
        .clk(clk), .rst(rst), .rxEn(rxEn), .rxIn(rxInV[0]),
        .rxBusy(busyV[0]), .rxDone(doneV[0]), .rxErr(errV[0]),
        .rxParityErr(perrV[0]), .rxBreak(brkV[0]), .rxOut(outA)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLOCK)) dutB (
        .clk(clk), .rst(rst), .rxEn(rxEn), .rxIn(rxInV[1]),
        .rxBusy(busyV[1]), .rxDone(doneV[1]), .rxErr(errV[1]),
        .rxParityErr(perrV[1]), .rxBreak(brkV[1]), .rxOut(outB)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLOCK), .STOP_BITS(2)) dutC (
        .clk(clk), .rst(rst), .rxEn(rxEn), .rxIn(rxInV[2]),
        .rxBusy(busyV[2]), .rxDone(doneV[2]), .rxErr(errV[2]),
        .rxParityErr(perrV[2]), .rxBreak(brkV[2]), .rxOut(outC)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLOCK), .DATA_BITS(7), .PARITY(2)) dutD (
        .clk(clk), .rst(rst), .rxEn(rxEn), .rxIn(rxInV[3]),
        .rxBusy(busyV[3]), .rxDone(doneV[3]), .rxErr(errV[3]),
        .rxParityErr(perrV[3]), .rxBreak(brkV[3]), .rxOut(outD)
    );

    // Capture every completed frame on the falling edge, and count any cycle
    // where a flag is raised without rxDone.
    always @(negedge clk) begin
        if (|doneV) begin
            doneCount = doneCount + 1;
            lastOut   = selOut;
            lastErr   = errV[sel];
            lastPerr  = perrV[sel];
            lastBrk   = brkV[sel];
            lastBusy  = busyV[sel];
        end
        flagLeak = flagLeak + $countones((errV | perrV | brkV) & ~doneV);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (observed !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit correctPbit(input logic [8:0] d, input int nBits, input bit oddPar);
        logic [8:0] m;
        m = d & 9'((1 << nBits) - 1);
        return ($countones(m) % 2 == 1) ^ oddPar;
    endfunction

    // Drive one frame: start, nBits data LSB first, optional parity bit,
    // nStop stop bits, then optionally hold the line low for tailLow clocks.
    // abortMode 1/2 cuts the frame in the middle of data bit 4 with a reset
    // pulse or by dropping rxEn, then releases the line high.
    task automatic applyStimulus(input logic [8:0] data, input int nBits,
                                 input bit hasParity, input bit pbit,
                                 input int nStop, input bit [1:0] stopVals,
                                 input int period, input int tailLow,
                                 input int abortMode);
        rxLine = 1'b0;
        waitClk(period);
        for (int i = 0; i < nBits; i++) begin
            rxLine = data[i];
            if (i == 4 && abortMode != 0) begin
                waitClk(period / 2);
                if (abortMode == 1) begin
                    rst = 1'b1;
                    waitClk(1);
                    rst    = 1'b0;
                    rxLine = 1'b1;
                end else begin
                    rxEn   = 1'b0;
                    rxLine = 1'b1;
                    waitClk(1);
                end
                return;
            end
            waitClk(period);
        end
        if (hasParity) begin
            rxLine = pbit;
            waitClk(period);
        end
        for (int s = 0; s < nStop; s++) begin
            rxLine = stopVals[s];
            waitClk(period);
        end
        if (tailLow > 0) begin
            rxLine = 1'b0;
            waitClk(tailLow);
        end
        rxLine = 1'b1;
    endtask

    // Reference model: derive the expected word and flags from the frame
    // contents and compare against what was captured at rxDone.
    task automatic checkFrame(input string tag, input logic [8:0] data, input int nBits,
                              input bit hasParity, input bit oddPar, input bit pbit,
                              input int nStop, input bit [1:0] stopVals, input int prev);
        logic [8:0] expOut;
        bit         expErr, expPerr, expBrk;
        int         ones;
        expOut = data & 9'((1 << nBits) - 1);
        expErr = 1'b0;
        for (int s = 0; s < nStop; s++)
            if (!stopVals[s]) expErr = 1'b1;
        ones    = $countones(expOut) + int'(pbit);
        expPerr = hasParity && ((ones % 2 == 1) != oddPar);
        expBrk  = expErr && (expOut == 9'd0) && !(hasParity && pbit);
        checkOutput({tag, ".done"}, doneCount, prev + 1);
        checkOutput({tag, ".out"},  lastOut, expOut);
        checkOutput({tag, ".err"},  lastErr, expErr);
        checkOutput({tag, ".perr"}, lastPerr, expPerr);
        checkOutput({tag, ".brk"},  lastBrk, expBrk);
        checkOutput({tag, ".busy"}, lastBusy, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        rxEn   = 1'b1;
        rxLine = 1'b1;
        sel    = 0;
        waitClk(3);
        checkOutput("reset.busy", selBusy, 1'b0);
        checkOutput("reset.done", doneV, 4'b0);
        checkOutput("reset.flags", {errV, perrV, brkV}, 12'b0);
        checkOutput("reset.out", selOut, 9'h000);
        rst = 1'b0;
        waitClk(10);

        // Default-rate 8N1 frame.
        sel = 0;
        prevDone = doneCount;
        applyStimulus(9'h35, 8, 0, 0, 1, 2'b11, 1248, 0, 0);
        waitClk(50);
        checkFrame("basic", 9'h35, 8, 0, 0, 0, 1, 2'b11, prevDone);

        // Short low glitch: start detected, then rejected by the start vote.
        prevDone = doneCount;
        rxLine = 1'b0;
        waitClk(300);
        rxLine = 1'b1;
        checkOutput("falseStart.busyHigh", selBusy, 1'b1);
        waitClk(490);
        checkOutput("falseStart.busyLow", selBusy, 1'b0);
        waitClk(1500);
        checkOutput("falseStart.noDone", doneCount, prevDone);

        // Framing error, then a break held low well past the frame.
        sel = 1;
        prevDone = doneCount;
        applyStimulus(9'h35, 8, 0, 0, 1, 2'b10, 128, 0, 0);
        waitClk(50);
        checkFrame("stopErr", 9'h35, 8, 0, 0, 0, 1, 2'b10, prevDone);
        prevDone = doneCount;
        applyStimulus(9'h00, 8, 0, 0, 1, 2'b10, 128, 3000, 0);
        waitClk(50);
        checkFrame("break", 9'h00, 8, 0, 0, 0, 1, 2'b10, prevDone);
        prevDone = doneCount;
        applyStimulus(9'h5A, 8, 0, 0, 1, 2'b11, 128, 0, 0);
        waitClk(50);
        checkFrame("afterBreak", 9'h5A, 8, 0, 0, 0, 1, 2'b11, prevDone);

        // 7E1 with correct and wrong parity.
        sel = 3;
        prevDone = doneCount;
        applyStimulus(9'h41, 7, 1, 0, 1, 2'b11, 128, 0, 0);
        waitClk(50);
        checkFrame("parityOk", 9'h41, 7, 1, 0, 0, 1, 2'b11, prevDone);
        prevDone = doneCount;
        applyStimulus(9'h41, 7, 1, 1, 1, 2'b11, 128, 0, 0);
        waitClk(50);
        checkFrame("parityBad", 9'h41, 7, 1, 0, 1, 1, 2'b11, prevDone);

        // 8N2 at roughly +3% and -3% baud error.
        sel = 2;
        prevDone = doneCount;
        applyStimulus(9'h35, 8, 0, 0, 2, 2'b11, 132, 0, 0);
        waitClk(50);
        checkFrame("slowBaud", 9'h35, 8, 0, 0, 0, 2, 2'b11, prevDone);
        prevDone = doneCount;
        applyStimulus(9'hCA, 8, 0, 0, 2, 2'b11, 124, 0, 0);
        waitClk(50);
        checkFrame("fastBaud", 9'hCA, 8, 0, 0, 0, 2, 2'b11, prevDone);

        // Reset in the middle of data bit 4.
        sel = 1;
        prevDone = doneCount;
        applyStimulus(9'hA5, 8, 0, 0, 1, 2'b11, 128, 0, 1);
        checkOutput("rstAbort.busy", selBusy, 1'b0);
        checkOutput("rstAbort.out", selOut, 9'h000);
        checkOutput("rstAbort.flags", {errV, perrV, brkV, doneV}, 16'b0);
        waitClk(1500);
        checkOutput("rstAbort.noDone", doneCount, prevDone);
        prevDone = doneCount;
        applyStimulus(9'hA5, 8, 0, 0, 1, 2'b11, 128, 0, 0);
        waitClk(50);
        checkFrame("afterRst", 9'hA5, 8, 0, 0, 0, 1, 2'b11, prevDone);

        // Enable dropped in the middle of data bit 4.
        prevDone = doneCount;
        applyStimulus(9'h3C, 8, 0, 0, 1, 2'b11, 128, 0, 2);
        checkOutput("enAbort.busy", selBusy, 1'b0);
        waitClk(5);
        rxEn = 1'b1;
        waitClk(1500);
        checkOutput("enAbort.noDone", doneCount, prevDone);
        checkOutput("enAbort.outHeld", selOut, 9'h0A5);

        // Random frames on the fast receivers.
        for (int n = 0; n < 12; n++) begin
            rSel    = $urandom_range(1, 3);
            rData   = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom);
            rBits   = (rSel == 3) ? 7 : 8;
            rHasPar = (rSel == 3);
            rStop   = (rSel == 2) ? 2 : 1;
            rPbit   = rHasPar ? (correctPbit(rData, rBits, 1'b0) ^ ($urandom_range(0, 3) == 0)) : 1'b0;
            rStopV[0] = ($urandom_range(0, 4) != 0);
            rStopV[1] = ($urandom_range(0, 4) != 0);
            rPeriod = $urandom_range(126, 130);
            sel = rSel;
            prevDone = doneCount;
            applyStimulus(rData, rBits, rHasPar, rPbit, rStop, rStopV, rPeriod, 0, 0);
            waitClk(40);
            checkFrame($sformatf("rand%0d", n), rData, rBits, rHasPar, 1'b0, rPbit,
                       rStop, rStopV, prevDone);
        end

        checkOutput("flagLeak", flagLeak, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
